// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl
//   Front-end controller for the digital clock manager. Two raw push buttons
//   are synchronised and debounced. A debounced press steps a 3-bit program
//   code up or down, with wrap-around. The code is then loaded into the clock
//   manager through a stretched update_clock strobe. Once the strobe has
//   finished, the program code echoed back by the clock manager is compared
//   with the code that was sent.
//
// Ports
//   clock         system clock; all logic runs on the rising edge
//   reset         asynchronous, active-high; clears all state
//   btn_up        raw button, increments the program code
//   btn_down      raw button, decrements the program code
//   prog_echo     program code echoed back by the clock manager
//   prog_sel      program code driven to the clock manager
//   update_clock  load strobe, high for UPDATE_CYCLES cycles per update
//   busy          high while an update sequence is running
//   mismatch      result of the last echo check; held until the next check
//
// Sequencer states
//   state | meaning
//   IDLE  | waiting for a single debounced press event
//   SETUP | new prog_sel settling, strobe still low
//   PULSE | update_clock high, pulse down-counter running
//   CHECK | strobe low, echo compared against prog_sel

module dcm_prog_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int UPDATE_CYCLES   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [2:0] prog_echo,
    output logic [2:0] prog_sel,
    output logic       update_clock,
    output logic       busy,
    output logic       mismatch
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(UPDATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Bit 0 carries the up button and bit 1 carries the down button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    press;
    logic          up_evt;
    logic          down_evt;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;
    logic [2:0]    sel_n;
    logic          upd_n;
    logic          busy_n;
    logic          mis_n;

    assign raw = {btn_down, btn_up};

    // The debounce counter counts consecutive cycles in which the synchronised
    // input differs from the accepted level. When the count reaches
    // DEBOUNCE_CYCLES, the new level is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // A press event is the single cycle after a debounced 0->1 transition.
    // A release does not produce an event.
    assign press    = deb & ~deb_q;
    assign up_evt   = press[0];
    assign down_evt = press[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pcnt         <= '0;
            prog_sel     <= '0;
            update_clock <= 1'b0;
            busy         <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            state        <= state_n;
            pcnt         <= pcnt_n;
            prog_sel     <= sel_n;
            update_clock <= upd_n;
            busy         <= busy_n;
            mismatch     <= mis_n;
        end
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        sel_n   = prog_sel;
        mis_n   = mismatch;
        case (state)
            IDLE: begin
                // If both buttons fire in the same cycle, the intent is ambiguous,
                // so the press is ignored.
                if (up_evt && !down_evt) begin
                    sel_n   = prog_sel + 3'd1;
                    state_n = SETUP;
                end else if (down_evt && !up_evt) begin
                    sel_n   = prog_sel - 3'd1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                pcnt_n  = PULSE_LAST;
                state_n = PULSE;
            end
            PULSE: begin
                if (pcnt == '0) begin
                    state_n = CHECK;
                end else begin
                    pcnt_n = pcnt - PW'(1);
                end
            end
            CHECK: begin
                mis_n   = (prog_echo != prog_sel);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // The outputs are registered and are decoded from the next state, so
        // they line up with the state register.
        upd_n  = (state_n == PULSE);
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
module tb_dcm_prog_ctrl;

    localparam int DEB = 4;
    localparam int UPD = 2;

    logic       clock;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic [2:0] prog_echo;
    logic [2:0] prog_sel;
    logic       update_clock;
    logic       busy;
    logic       mismatch;

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .UPDATE_CYCLES  (UPD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .prog_echo   (prog_echo),
        .prog_sel    (prog_sel),
        .update_clock(update_clock),
        .busy        (busy),
        .mismatch    (mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model. The input delay line has length 2, and the debounce
    // rule is "DEB consecutive differing samples". The sequencer is modelled
    // as the number of cycles since a press was accepted (-1 means idle).
    int r1 [2];
    int r2 [2];
    int debm [2];
    int run [2];
    bit ev [2];
    int phase;
    int sel_m;
    bit mis_m;
    int echo_force;
    int upd_cycles;
    int busy_cycles;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            r1[i] = 0; r2[i] = 0; debm[i] = 0; run[i] = 0; ev[i] = 1'b0;
        end
        phase = -1;
        sel_m = 0;
        mis_m = 1'b0;
    endtask

    task automatic model_edge();
        int raw [2];
        int seen;
        raw[0] = int'(btn_up);
        raw[1] = int'(btn_down);
        if (phase < 0) begin
            if (ev[0] != ev[1]) begin
                sel_m = ev[0] ? (sel_m + 1) % 8 : (sel_m + 7) % 8;
                phase = 1;
            end
        end else if (phase == UPD + 2) begin
            mis_m = (int'(prog_echo) != sel_m);
            phase = -1;
        end else begin
            phase++;
        end
        for (int i = 0; i < 2; i++) begin
            seen  = r2[i];
            r2[i] = r1[i];
            r1[i] = raw[i];
            ev[i] = 1'b0;
            if (seen != debm[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    debm[i] = seen;
                    run[i]  = 0;
                    ev[i]   = (seen == 1);
                end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    // One clock cycle: drive the echo, apply the edge to the model, then
    // compare all outputs at the falling edge.
    task automatic step();
        int e;
        e = (echo_force >= 0) ? echo_force : sel_m;
        prog_echo = e[2:0];
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        @(negedge clock);
        check("prog_sel", 8'(prog_sel), 8'(sel_m));
        check("update_clock", 8'(update_clock), 8'(phase >= 2 && phase <= UPD + 1));
        check("busy", 8'(busy), 8'(phase >= 1));
        check("mismatch", 8'(mismatch), 8'(mis_m));
        upd_cycles  += int'(update_clock);
        busy_cycles += int'(busy);
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int idle);
        btn_up   = up;
        btn_down = dn;
        repeat (hold) step();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (idle) step();
    endtask

    initial begin
        int start;
        int n;
        reset      = 1'b1;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        prog_echo  = 3'd0;
        echo_force = -1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_prog_sel", 8'(prog_sel), 8'd0);
        check("rst_update_clock", 8'(update_clock), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_mismatch", 8'(mismatch), 8'd0);
        reset = 1'b0;

        // Test 1: a single held press.
        upd_cycles = 0; busy_cycles = 0;
        press(1'b1, 1'b0, 10, 14);
        check("t1_prog_sel", 8'(prog_sel), 8'd1);
        check("t1_upd_cycles", 8'(upd_cycles), 8'(UPD));
        check("t1_busy_cycles", 8'(busy_cycles), 8'(UPD + 2));

        // Test 2: wrap-around in both directions.
        for (int i = 0; i < 8 && sel_m != 7; i++) press(1'b1, 1'b0, 8, 14);
        check("t2_at_seven", 8'(prog_sel), 8'd7);
        press(1'b1, 1'b0, 8, 14);
        check("t2_wrap_up", 8'(prog_sel), 8'd0);
        press(1'b0, 1'b1, 8, 14);
        check("t2_wrap_down", 8'(prog_sel), 8'd7);

        // Test 3: a bouncing input shorter than the debounce window.
        start = sel_m; upd_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            repeat (2) step();
        end
        btn_up = 1'b0;
        repeat (10) step();
        check("t3_sel_unchanged", 8'(prog_sel), 8'(start));
        check("t3_no_update", 8'(upd_cycles), 8'd0);

        // Test 4: simultaneous presses, then a press that arrives while busy.
        start = sel_m; upd_cycles = 0;
        press(1'b1, 1'b1, 8, 14);
        check("t4_both_sel", 8'(prog_sel), 8'(start));
        check("t4_both_no_update", 8'(upd_cycles), 8'd0);
        btn_up = 1'b1;
        repeat (2) step();
        btn_down = 1'b1;
        repeat (8) step();
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (14) step();
        check("t4_busy_drop", 8'(prog_sel), 8'((start + 1) % 8));

        // A long hold produces only one event.
        start = sel_m;
        press(1'b1, 1'b0, 30, 14);
        check("hold_one_event", 8'(prog_sel), 8'((start + 1) % 8));

        // Test 5: a wrong echo sets mismatch, and a correct echo clears it.
        for (int i = 0; i < 8 && sel_m != 1; i++) press(1'b1, 1'b0, 8, 14);
        echo_force = 3;
        press(1'b1, 1'b0, 8, 14);
        check("t5_sel_two", 8'(prog_sel), 8'd2);
        check("t5_mismatch_set", 8'(mismatch), 8'd1);
        echo_force = -1;
        press(1'b0, 1'b1, 8, 14);
        check("t5_mismatch_clear", 8'(mismatch), 8'd0);

        // Test 6: reset asserted during PULSE, with mismatch previously set.
        echo_force = (sel_m + 5) % 8;
        press(1'b1, 1'b0, 8, 14);
        echo_force = -1;
        check("t6_pre_mismatch", 8'(mismatch), 8'd1);
        btn_up = 1'b1;
        n = 0;
        while (update_clock !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("t6_reach_pulse", 8'(update_clock), 8'd1);
        reset  = 1'b1;
        btn_up = 1'b0;
        #1;
        check("t6_async_update_clock", 8'(update_clock), 8'd0);
        check("t6_async_prog_sel", 8'(prog_sel), 8'd0);
        check("t6_async_busy", 8'(busy), 8'd0);
        check("t6_async_mismatch", 8'(mismatch), 8'd0);
        step();
        reset = 1'b0;
        repeat (4) step();
        press(1'b1, 1'b0, 8, 14);
        check("t6_resume", 8'(prog_sel), 8'd1);

        // Randomised presses, holds and echo corruption against the model.
        for (int s = 0; s < 40; s++) begin
            echo_force = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 10)), int'($urandom_range(0, 8)));
        end
        echo_force = -1;
        repeat (16) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
